// File: rtl/popcount_stream_pkg.sv
// Shared register offsets, CTRL/STATUS bit positions and the byte popcount
// used by the popcount_stream engine.
package popcount_stream_pkg;

    localparam int unsigned OFS_CTRL  = 'h0;
    localparam int unsigned OFS_COUNT = 'h4;
    localparam int unsigned OFS_PKTS  = 'h8;
    localparam int unsigned OFS_LAST  = 'hC;

    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_INVERT_BIT = 1;
    localparam int STAT_BUSY_BIT   = 8;
    localparam int STAT_SAT_BIT    = 9;

    function automatic logic [3:0] byte_popcount(input logic [7:0] b);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, b[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/popcount_tree.sv
// Stage 1 registers masked per-byte counts; their sum is presented
// combinationally so the owner can fold it into its accumulators one edge later.
module popcount_tree
    import popcount_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int NUM_BYTES = DATA_WIDTH / 8,
    localparam int CNT_W     = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_invert,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [NUM_BYTES-1:0]  in_keep,
    output logic                  s1_valid,
    output logic [CNT_W-1:0]      sum
);

    logic [3:0] byte_cnt [NUM_BYTES];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            for (int i = 0; i < NUM_BYTES; i++) begin
                byte_cnt[i] <= '0;
            end
        end else begin
            s1_valid <= in_valid && !flush;
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (in_keep[i]) begin
                    byte_cnt[i] <= byte_popcount(in_invert ? ~in_data[8*i +: 8]
                                                           :  in_data[8*i +: 8]);
                end else begin
                    byte_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            sum = sum + CNT_W'(byte_cnt[i]);
        end
    end

endmodule

// File: rtl/popcount_stream.sv
// Streaming/MMIO popcount engine: register decode, saturating COUNT,
// per-packet LAST/PKTS tracking and registered read-back.
module popcount_stream
    import popcount_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    input  logic                    reg_wr_en,
    input  logic                    reg_rd_en,
    input  logic [ADDR_WIDTH-1:0]   reg_addr,
    input  logic [31:0]             reg_wr_data,
    output logic [31:0]             reg_rd_data,
    output logic                    reg_rd_valid
);

    localparam int S_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int M_CNT_W = $clog2(32 + 1);
    // Headroom for the largest single-cycle add on top of a full accumulator.
    localparam int SUM_W   = COUNT_WIDTH + 11;

    localparam logic [ADDR_WIDTH-1:0] A_CTRL  = ADDR_WIDTH'(OFS_CTRL);
    localparam logic [ADDR_WIDTH-1:0] A_COUNT = ADDR_WIDTH'(OFS_COUNT);
    localparam logic [ADDR_WIDTH-1:0] A_PKTS  = ADDR_WIDTH'(OFS_PKTS);
    localparam logic [ADDR_WIDTH-1:0] A_LAST  = ADDR_WIDTH'(OFS_LAST);
    localparam logic [SUM_W-1:0]      CNT_MAX = (SUM_W'(1) << COUNT_WIDTH) - SUM_W'(1);

    function automatic logic [COUNT_WIDTH-1:0] clip(input logic [SUM_W-1:0] v);
        return (v > CNT_MAX) ? COUNT_WIDTH'(CNT_MAX) : v[COUNT_WIDTH-1:0];
    endfunction

    logic                   ready_q, invert_q, sat_q, s1_last;
    logic [COUNT_WIDTH-1:0] count_q, pkt_q, last_q;
    logic [31:0]            pkts_q;

    logic ctrl_wr, clear, mmio_add, beat_acc;
    assign ctrl_wr       = reg_wr_en && (reg_addr == A_CTRL);
    assign clear         = ctrl_wr && reg_wr_data[CTRL_CLEAR_BIT];
    assign mmio_add      = reg_wr_en && (reg_addr == A_COUNT);
    assign s_axis_tready = ready_q && !clear;
    assign beat_acc      = s_axis_tvalid && s_axis_tready;

    logic               s_valid, m_valid;
    logic [S_CNT_W-1:0] s_sum;
    logic [M_CNT_W-1:0] m_sum;

    popcount_tree #(.DATA_WIDTH(DATA_WIDTH)) u_stream_tree (
        .clk       (clk),
        .rst       (rst),
        .flush     (clear),
        .in_valid  (beat_acc),
        .in_invert (invert_q),
        .in_data   (s_axis_tdata),
        .in_keep   (s_axis_tkeep),
        .s1_valid  (s_valid),
        .sum       (s_sum)
    );

    popcount_tree #(.DATA_WIDTH(32)) u_mmio_tree (
        .clk       (clk),
        .rst       (rst),
        .flush     (clear),
        .in_valid  (mmio_add),
        .in_invert (invert_q),
        .in_data   (reg_wr_data),
        .in_keep   (4'hF),
        .s1_valid  (m_valid),
        .sum       (m_sum)
    );

    logic [SUM_W-1:0] stream_add, mmio_cnt, count_raw, pkt_raw;
    logic [31:0]      status, rd_mux;

    always_comb begin
        stream_add = s_valid ? SUM_W'(s_sum) : '0;
        mmio_cnt   = m_valid ? SUM_W'(m_sum) : '0;
        count_raw  = SUM_W'(count_q) + stream_add + mmio_cnt;
        pkt_raw    = SUM_W'(pkt_q) + stream_add;
    end

    always_comb begin
        status                  = '0;
        status[CTRL_INVERT_BIT] = invert_q;
        status[STAT_BUSY_BIT]   = s_valid || m_valid;
        status[STAT_SAT_BIT]    = sat_q;
        rd_mux = '0;
        if (reg_addr == A_CTRL)       rd_mux = status;
        else if (reg_addr == A_COUNT) rd_mux = 32'(count_q);
        else if (reg_addr == A_PKTS)  rd_mux = pkts_q;
        else if (reg_addr == A_LAST)  rd_mux = 32'(last_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q      <= 1'b0;
            invert_q     <= 1'b0;
            sat_q        <= 1'b0;
            s1_last      <= 1'b0;
            count_q      <= '0;
            pkt_q        <= '0;
            last_q       <= '0;
            pkts_q       <= '0;
            reg_rd_valid <= 1'b0;
            reg_rd_data  <= '0;
        end else begin
            ready_q      <= 1'b1;
            reg_rd_valid <= reg_rd_en;
            if (reg_rd_en) reg_rd_data <= rd_mux;
            s1_last <= beat_acc && s_axis_tlast;
            // A clearing write leaves INVERT as it was.
            if (ctrl_wr && !reg_wr_data[CTRL_CLEAR_BIT]) invert_q <= reg_wr_data[CTRL_INVERT_BIT];
            if (clear) begin
                sat_q   <= 1'b0;
                count_q <= '0;
                pkt_q   <= '0;
                last_q  <= '0;
                pkts_q  <= '0;
            end else begin
                count_q <= clip(count_raw);
                if (count_raw > CNT_MAX) sat_q <= 1'b1;
                if (s_valid && s1_last) begin
                    last_q <= clip(pkt_raw);
                    pkt_q  <= '0;
                    pkts_q <= pkts_q + 32'd1;
                end else begin
                    pkt_q  <= clip(pkt_raw);
                end
            end
        end
    end

endmodule
